// File: rtl/cache_mem_responder.sv
// cache_mem_responder: word-organised memory serving cache word/line reads and writes; CACHE_MEM_RAND_DELAY_EN adds LFSR return bubbles
module cache_mem_responder #(
  parameter int          MEM_WORDS = 4096,
  parameter int          RD_LAT    = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy
);
  localparam int AW = $clog2(MEM_WORDS);
  typedef enum logic [1:0] {IDLE, WR_DRAIN, RD_WAIT, RD_RET} state_t;
  localparam state_t RD_FIRST = (RD_LAT == 1) ? RD_RET : RD_WAIT;
  state_t state, state_n;
  logic [31:0] mem [MEM_WORDS];
  logic [AW-1:0] wr_idx, rd_idx, w_word_idx, r_word_idx;
  logic wr_line, rd_line, rd_pend, bubble, beat, drain_done;
  logic [3:0] wr_strb, w_strb;
  logic [127:0] wr_buf;
  logic [31:0] w_word, hold;
  logic [1:0] cnt;
  logic [15:0] wcnt;
  logic unused_bits;
  assign unused_bits = ^{rd_addr[31:AW+2], rd_addr[1:0], wr_addr[31:AW+2], wr_addr[1:0], LFSR_SEED};
`ifdef CACHE_MEM_RAND_DELAY_EN
  logic [15:0] lfsr;
  logic [1:0] bub;
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
      bub  <= 2'd0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      bub  <= (state == RD_RET && bubble) ? bub + 2'd1 : 2'd0;
    end
  end
  // a fourth consecutive bubble is suppressed so a beat is forced
  assign bubble = lfsr[0] && bub != 2'd3;
`else
  assign bubble = 1'b0;
`endif
  always_comb begin
    state_n    = state;
    beat       = state == RD_RET && !bubble;
    drain_done = state == WR_DRAIN && (!wr_line || cnt == 2'd3);
    case (state)
      IDLE:     state_n = wr_req ? WR_DRAIN : rd_req ? RD_FIRST : IDLE;
      WR_DRAIN: state_n = drain_done ? (rd_pend ? RD_FIRST : IDLE) : WR_DRAIN;
      RD_WAIT:  state_n = (wcnt == 16'(RD_LAT - 2)) ? RD_RET : RD_WAIT;
      default:  state_n = (beat && (!rd_line || cnt == 2'd3)) ? IDLE : RD_RET;
    endcase
  end
  assign rd_rdy     = state == IDLE && !reset;
  assign wr_rdy     = rd_rdy;
  assign ret_valid  = beat && !reset;
  assign ret_last   = ret_valid && (!rd_line || cnt == 2'd3);
  assign r_word_idx = rd_line ? {rd_idx[AW-1:2], cnt} : rd_idx;
  assign ret_data   = ret_valid ? mem[r_word_idx] : hold;
  assign w_word_idx = wr_line ? {wr_idx[AW-1:2], cnt} : wr_idx;
  assign w_word     = wr_line ? wr_buf[32*cnt +: 32] : wr_buf[31:0];
  assign w_strb     = wr_line ? 4'hF : wr_strb;
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      wcnt    <= 16'd0;
      hold    <= 32'd0;
      rd_pend <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (drain_done || ret_last) ? 2'd0 : (state == WR_DRAIN || beat) ? cnt + 2'd1 : cnt;
      wcnt  <= (state == RD_WAIT) ? wcnt + 16'd1 : 16'd0;
      if (ret_valid) hold <= ret_data;
      if (state == IDLE) rd_pend <= rd_req;
      if (state == IDLE && wr_req) begin
        wr_idx  <= wr_addr[AW+1:2];
        wr_line <= wr_type == 3'b100;
        wr_strb <= wr_wstrb;
        wr_buf  <= wr_data;
      end
      if (state == IDLE && rd_req) begin
        rd_idx  <= rd_addr[AW+1:2];
        rd_line <= rd_type == 3'b100;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && state == WR_DRAIN)
      for (int b = 0; b < 4; b++)
        if (w_strb[b]) mem[w_word_idx][8*b +: 8] <= w_word[8*b +: 8];
  end
endmodule

// File: tb/tb_cache_mem_responder.sv
// tb_cache_mem_responder: randomized word/line traffic checked against an array reference model
module tb_cache_mem_responder;
  localparam int RD_LAT = 2;
  logic clk = 0, reset = 1;
  logic rd_req = 0, rd_rdy, ret_valid, ret_last, wr_req = 0, wr_rdy;
  logic [2:0] rd_type = 0, wr_type = 0;
  logic [31:0] rd_addr = 0, wr_addr = 0, ret_data;
  logic [3:0] wr_wstrb = 0;
  logic [127:0] wr_data = 0;
  logic [31:0] model [0:4095];
  int errors = 0, checks = 0, cyc = 0;

  cache_mem_responder #(.MEM_WORDS(4096), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr),
    .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_write(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s, input logic [127:0] d);
    if (t == 3'b100)
      for (int k = 0; k < 4; k++) model[{a[13:4], 2'(k)}] = d[32*k +: 32];
    else
      for (int b = 0; b < 4; b++)
        if (s[b]) model[a[13:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic xact(input string tag, input bit w, input logic [2:0] wt, input logic [31:0] wa,
                      input logic [3:0] ws, input logic [127:0] wd,
                      input bit r, input logic [2:0] rt, input logic [31:0] ra);
    int n, waited, acc;
    logic [31:0] exp;
    wr_req = w; wr_type = wt; wr_addr = wa; wr_wstrb = ws; wr_data = wd;
    rd_req = r; rd_type = rt; rd_addr = ra;
    waited = 0;
    @(negedge clk);
    while (!rd_rdy && waited < 100) begin @(negedge clk); waited++; end
    if (!rd_rdy) begin
      check({tag, "_accept"}, 0, 1);
      wr_req = 0; rd_req = 0;
      return;
    end
    @(posedge clk); #1;
    acc = cyc;
    wr_req = 0; rd_req = 0;
    if (w) model_write(wt, wa, ws, wd);
    if (!r) return;
    n = (rt == 3'b100) ? 4 : 1;
    for (int k = 0; k < n; k++) begin
      waited = 0;
      @(negedge clk);
      while (!ret_valid && waited < 50) begin @(negedge clk); waited++; end
      if (!ret_valid) begin
        check({tag, "_beat_timeout"}, 0, 1);
        return;
      end
`ifndef CACHE_MEM_RAND_DELAY_EN
      if (k == 0 && !w) check({tag, "_latency"}, cyc - acc + 1, RD_LAT);
      if (k > 0) check({tag, "_gap"}, waited, 0);
`endif
      exp = (n == 4) ? model[{ra[13:4], 2'(k)}] : model[ra[13:2]];
      check({tag, "_data"}, ret_data, exp);
      check({tag, "_last"}, ret_last, k == n - 1);
    end
    @(negedge clk);
    check({tag, "_idle"}, {ret_valid, rd_rdy}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [127:0] d;
    logic [2:0] t;
    int op, beats, stray;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rdy", {rd_rdy, wr_rdy, ret_valid, ret_last}, 4'b0000);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    check("post_reset_rdy", {rd_rdy, wr_rdy, ret_valid}, 3'b110);
    check("post_reset_data", ret_data, 32'h0);

    xact("pre_word", 1, 3'b000, 32'h1000, 4'hF, 128'h11223344, 0, 0, 0);
    xact("strb_write", 1, 3'b010, 32'h1000, 4'b0011, 128'hAABBCCDD, 0, 0, 0);
    xact("strb_read", 0, 0, 0, 0, 0, 1, 3'b010, 32'h1000);
    xact("line_write", 1, 3'b100, 32'h2000, 4'h0, {32'hD, 32'hC, 32'hB, 32'hA}, 0, 0, 0);
    xact("line_read", 0, 0, 0, 0, 0, 1, 3'b100, 32'h2008);
    xact("old_3000", 1, 3'b100, 32'h3000, 4'h0, {4{32'h5555_0000}}, 0, 0, 0);
    xact("same_cycle", 1, 3'b100, 32'h3000, 4'h0, {32'h44, 32'h33, 32'h22, 32'h11}, 1, 3'b100, 32'h3000);
    xact("alias_write", 1, 3'b000, 32'h0001_0000, 4'hF, 128'hCAFEF00D, 0, 0, 0);
    xact("alias_read", 0, 0, 0, 0, 0, 1, 3'b000, 32'h0000_0000);

    // abandon a line read during its second beat
    rd_req = 1; rd_type = 3'b100; rd_addr = 32'h2000;
    @(negedge clk);
    @(posedge clk); #1 rd_req = 0;
    beats = 0; stray = 0;
    while (beats < 2 && stray < 50) begin
      @(negedge clk);
      if (ret_valid) beats++; else stray++;
    end
    check("rst_mid_beats_seen", beats, 2);
    reset = 1;
    #1 check("rst_mid_during", {ret_valid, rd_rdy}, 2'b00);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    check("rst_mid_after", {ret_valid, rd_rdy, wr_rdy}, 3'b011);
    check("rst_mid_data", ret_data, 32'h0);
    stray = 0;
    repeat (8) begin @(negedge clk); if (ret_valid) stray++; end
    check("rst_mid_stale", stray, 0);

    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      xact("preload", 1, 3'b100, 32'h4000 + 32'(16 * i), 4'h0, d, 0, 0, 0);
    end
    for (int i = 0; i < 100; i++) begin
      op = $urandom_range(0, 3);
      a = $urandom; a[13:8] = 6'h10;
      d = {$urandom, $urandom, $urandom, $urandom};
      t = $urandom_range(0, 1) ? 3'b100 : 3'($urandom_range(0, 7));
      if (op == 1)
        xact("rand_write", 1, t, a, 4'($urandom), d, 0, 0, 0);
      else if (op == 2) begin
        xact("rand_both", 1, t, a, 4'($urandom), d, 1, $urandom_range(0, 1) ? 3'b100 : 3'b010, a);
      end else begin
        a[31:14] = 18'($urandom);
        xact("rand_read", 0, 0, 0, 0, 0, 1, t, a);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
